// File: rtl/spi_px_master.sv
// SPI mode-0 master for the pixel link: one PX_BITS word per chip-select frame, MSB first.
// Define SPI_PX_MASTER_RX_EN to keep the full-duplex receive path; otherwise MISO is ignored.
module spi_px_master #(
    parameter int PX_BITS = 24,
    parameter int CLK_DIV = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [PX_BITS-1:0] tx_data_i,
    input  logic               tx_valid_i,
    output logic               tx_ready_o,
    output logic [PX_BITS-1:0] rx_data_o,
    output logic               rx_valid_o,
    output logic               busy_o,
    output logic               spi_sck_o,
    output logic               spi_cs_o,
    output logic               spi_mosi_o,
    input  logic               spi_miso_i
);

    localparam int BW = $clog2(PX_BITS + 1);
    localparam logic [7:0]    DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(PX_BITS - 1);
    localparam logic [BW-1:0] BIT_FULL = BW'(PX_BITS);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         div_q, div_d;
    logic [BW-1:0]      bit_q, bit_d;
    logic [PX_BITS-1:0] tx_sh_q, tx_sh_d;
    logic               tx_ready_q, tx_ready_d;
    logic               busy_q, busy_d;
    logic               sck_q, sck_d;
    logic               cs_q, cs_d;
    logic               mosi_q, mosi_d;
    logic               div_end_s;
    logic               sample_s;
    logic               commit_s;

    assign div_end_s = (div_q == DIV_LAST);

    // Next-state and output logic; sck_q doubles as the high/low half marker in SHIFT.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        tx_sh_d    = tx_sh_q;
        tx_ready_d = tx_ready_q;
        busy_d     = busy_q;
        sck_d      = sck_q;
        cs_d       = cs_q;
        mosi_d     = mosi_q;
        sample_s   = 1'b0;
        commit_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tx_valid_i) begin
                    tx_sh_d    = tx_data_i;
                    bit_d      = '0;
                    div_d      = 8'd0;
                    cs_d       = 1'b0;
                    mosi_d     = tx_data_i[PX_BITS-1];
                    tx_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = ST_SETUP;
                end else begin
                    tx_ready_d = 1'b1;
                end
            end
            ST_SETUP: begin
                if (div_end_s) begin
                    div_d    = 8'd0;
                    sck_d    = 1'b1;
                    sample_s = 1'b1;
                    state_d  = ST_SHIFT;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            ST_SHIFT: begin
                if (!div_end_s) begin
                    div_d = div_q + 8'd1;
                end else if (sck_q) begin
                    div_d = 8'd0;
                    sck_d = 1'b0;
                    bit_d = bit_q + BIT_ONE;
                    if (bit_q != BIT_LAST) begin
                        tx_sh_d = {tx_sh_q[PX_BITS-2:0], 1'b0};
                        mosi_d  = tx_sh_q[PX_BITS-2];
                    end else begin
                        mosi_d = mosi_q;
                    end
                end else if (bit_q == BIT_FULL) begin
                    div_d   = 8'd0;
                    state_d = ST_HOLD;
                end else begin
                    div_d    = 8'd0;
                    sck_d    = 1'b1;
                    sample_s = 1'b1;
                end
            end
            ST_HOLD: begin
                if (div_end_s) begin
                    div_d    = 8'd0;
                    cs_d     = 1'b1;
                    commit_s = 1'b1;
                    state_d  = ST_GAP;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            ST_GAP: begin
                if (div_end_s) begin
                    div_d      = 8'd0;
                    tx_ready_d = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = ST_IDLE;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                div_d      = 8'd0;
                bit_d      = '0;
                tx_ready_d = 1'b1;
                busy_d     = 1'b0;
                sck_d      = 1'b0;
                cs_d       = 1'b1;
                mosi_d     = 1'b0;
            end
        endcase
    end

    // Transmit-side state and pin registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            div_q      <= 8'd0;
            bit_q      <= '0;
            tx_sh_q    <= '0;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            sck_q      <= 1'b0;
            cs_q       <= 1'b1;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            tx_sh_q    <= tx_sh_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
            sck_q      <= sck_d;
            cs_q       <= cs_d;
            mosi_q     <= mosi_d;
        end
    end

    assign tx_ready_o = tx_ready_q;
    assign busy_o     = busy_q;
    assign spi_sck_o  = sck_q;
    assign spi_cs_o   = cs_q;
    assign spi_mosi_o = mosi_q;

`ifdef SPI_PX_MASTER_RX_EN
    logic [PX_BITS-1:0] rx_sh_q, rx_sh_d;
    logic [PX_BITS-1:0] rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;

    // Receive shift on each SCK rise, publish at the end of HOLD.
    always_comb begin
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        if (sample_s) begin
            rx_sh_d = {rx_sh_q[PX_BITS-2:0], spi_miso_i};
        end else begin
            rx_sh_d = rx_sh_q;
        end
        if (commit_s) begin
            rx_data_d  = rx_sh_q;
            rx_valid_d = 1'b1;
        end else begin
            rx_valid_d = 1'b0;
        end
    end

    // Receive registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
`else
    logic unused_rx_s;
    assign unused_rx_s = spi_miso_i ^ sample_s ^ commit_s;
    assign rx_data_o   = '0;
    assign rx_valid_o  = 1'b0;
`endif

endmodule

// File: doc/spi_px_master.md
# spi_px_master

SPI master that drives the pixel SPI link from the host side. It serialises one pixel word per transaction onto MOSI, and captures the word the slave returns on MISO in the same transaction. It is used as the stimulus/readback engine for the gray/sobel core, both in the FPGA test harness and on the bench. Its SPI pins connect directly to the core's SCK, CS and SDI inputs and to its SDO output.

## Interface
Parameters:
- PX_BITS, 24: bits per transaction (pixel word width), MSB first.
- CLK_DIV, 4: clk_i cycles per SCK half-period; legal range 1..255.

Ports:
- clk_i  in  1  single system clock.
- reset_i  in  1  asynchronous, active-high reset.
- tx_data_i  in  PX_BITS  pixel word to send.
- tx_valid_i  in  1  tx_data_i valid.
- tx_ready_o  out  1  block accepts a word; transfer happens when tx_valid_i && tx_ready_o at a rising edge.
- rx_data_o  out  PX_BITS  word captured from MISO in the last transaction; held until the next capture.
- rx_valid_o  out  1  one-cycle pulse when rx_data_o updates.
- busy_o  out  1  high from accept until return to IDLE.
- spi_sck_o  out  1  SPI clock, mode 0 (idle low).
- spi_cs_o  out  1  chip select, active low.
- spi_mosi_o  out  1  serial data to slave (slave's SDI).
- spi_miso_i  in  1  serial data from slave (slave's SDO); pre-synchronised externally.

## Operation
- Reset values: tx_ready_o=1, rx_data_o=0, rx_valid_o=0, busy_o=0, spi_sck_o=0, spi_cs_o=1, spi_mosi_o=0.
- Reset asserted mid-transfer: all outputs return to their reset values immediately, and the partial word is discarded. No rx_valid_o pulse is produced.
- FSM states: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE:
  - tx_ready_o=1.
  - On accept: tx_data_i is latched into the shift register, the bit counter and the divider are cleared, and the FSM moves to SETUP.
  - In the same transition spi_cs_o goes 0 and spi_mosi_o takes tx_data_i[PX_BITS-1].
- SETUP: CLK_DIV cycles with SCK low, giving MOSI setup time before the first rising edge. Then go to SHIFT.
- SHIFT: PX_BITS SCK periods.
  - Each period is a high half of CLK_DIV cycles, then a low half of CLK_DIV cycles.
  - On each SCK rise: spi_miso_i is sampled into the receive shift register (LSB in).
  - On each SCK fall (except after the last bit): MOSI advances to the next bit.
  - After the last low half, go to HOLD.
- HOLD: CLK_DIV cycles with CS still low and SCK low. At the end:
  - spi_cs_o goes 1.
  - The receive register is copied to rx_data_o.
  - rx_valid_o pulses for 1 cycle.
  - The FSM moves to GAP.
- GAP: CS high for CLK_DIV cycles (minimum deselect time), then go to IDLE.
- tx_ready_o=0 in every state except IDLE.
- Back-to-back traffic: if tx_valid_i is held high, the next word is accepted on the first IDLE cycle, so there is 1 IDLE cycle between transactions.
- tx_data_i changing after accept has no effect.
- Counters: the divider is 8 bits and the bit counter is clog2(PX_BITS+1) bits. No wrap-around is possible within a transaction.

## Timing
- Accept edge to CS falling: 1 clk.
- Accept edge to rx_valid_o pulse: CLK_DIV*(2*PX_BITS+2)+1 clk. With defaults: 4*50+1 = 201.
- rx_valid_o and CS rising occur in the same cycle.
- Accept edge to next tx_ready_o: CLK_DIV*(2*PX_BITS+3)+1 clk.
- SCK frequency: clk_i / (2*CLK_DIV).
- MOSI is stable for CLK_DIV cycles before and after every SCK rise.
- All outputs are registered, so no glitches appear on SCK or CS.

## Configuration
- SPI_PX_MASTER_RX_EN defined: the receive shift register and rx_data_o/rx_valid_o behave as above (full duplex).
- Not defined: the receive logic is removed. rx_data_o is tied to 0, rx_valid_o is tied to 0, and spi_miso_i is ignored. TX timing is unchanged.

## Test plan
- Reset then idle, PX_BITS=24, CLK_DIV=2: all outputs at reset values, no SCK edges for 100 cycles.
- Send 0xA5C3F0 with spi_miso_i looped to spi_mosi_o:
  - exactly 24 SCK rises while CS is low;
  - MOSI bit sequence at the rises equals 0xA5C3F0 MSB first;
  - rx_data_o=0xA5C3F0 with a single rx_valid_o pulse 101 cycles after accept.
- Back-to-back, tx_valid_i held with 0x000001 then 0xFFFFFE:
  - two transactions, CS high for ≥2 cycles between them;
  - rx_data_o sequence 0x000001, 0xFFFFFE (loopback).
- MISO tied to 1, CLK_DIV=1, word 0x000000: rx_data_o=0xFFFFFF and each SCK half-period is 1 cycle.
- reset_i pulsed after the 10th SCK rise: CS=1 and SCK=0 the same cycle, no rx_valid_o pulse. A following transfer of 0x123456 completes correctly.
- Build without SPI_PX_MASTER_RX_EN, loopback of 0xA5C3F0: MOSI waveform identical, rx_valid_o never asserts, rx_data_o=0.
